iter_alu: RTL

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/iter_alu_if.sv | 28 ++
 rtl/iter_alu.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu_if.sv
// Request/response bundle for iter_alu: operand handshake in, result handshake out.
interface iter_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUop;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] ResultHi;
  logic             Overflow;
  logic             CarryOut;
  logic             Zero;
  logic             DivZero;

  modport master (
    output in_valid, A, B, ALUop, out_ready,
    input  in_ready, out_valid, Result, ResultHi, Overflow, CarryOut, Zero, DivZero
  );

  modport slave (
    input  in_valid, A, B, ALUop, out_ready,
    output in_ready, out_valid, Result, ResultHi, Overflow, CarryOut, Zero, DivZero
  );
endinterface

// File: rtl/iter_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, bit-serial multiply and divide.
// Define ITER_ALU_DIV_EN to build the restoring divider (ops 12/13); otherwise they are reserved.
module iter_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic        clk,
  input  logic        resetn,
  iter_alu_if.slave   bus
);

  localparam int unsigned CW  = $clog2(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MULU = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
`ifdef ITER_ALU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'd12;
  localparam logic [3:0] OP_DIV  = 4'd13;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   resh_q;
  logic               ovf_q;
  logic               cry_q;
  logic               zero_q;
  logic               dz_q;

  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   mcand_q;
  logic               neg_q;
`ifdef ITER_ALU_DIV_EN
  logic               div_q;
  logic               neg_r_q;
  logic               divz_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH:0]     rem_s;
  logic [WIDTH:0]     trial;
`endif

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     dif;
  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   fast_res;
  logic               fast_ovf;
  logic               fast_cry;
  logic               is_iter;
  logic               signed_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   load_lo;
  logic [WIDTH-1:0]   load_mcand;

  logic [WIDTH:0]     add;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;
  logic               fin_dz;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Result    = res_q;
  assign bus.ResultHi  = resh_q;
  assign bus.Overflow  = ovf_q;
  assign bus.CarryOut  = cry_q;
  assign bus.Zero      = zero_q;
  assign bus.DivZero   = dz_q;

  // Single-cycle datapath and iterative-op setup, evaluated on the live request
  always_comb begin
    sum       = {1'b0, bus.A} + {1'b0, bus.B};
    dif       = {1'b0, bus.A} - {1'b0, bus.B};
    sh        = bus.A[SHW-1:0];
    fast_res  = '0;
    fast_ovf  = 1'b0;
    fast_cry  = 1'b0;
    is_iter   = 1'b0;
    case (bus.ALUop)
      OP_AND:  fast_res = bus.A & bus.B;
      OP_OR:   fast_res = bus.A | bus.B;
      OP_ADD: begin
        fast_res = sum[WIDTH-1:0];
        fast_ovf = (bus.A[MSB] == bus.B[MSB]) && (sum[MSB] != bus.A[MSB]);
        fast_cry = sum[WIDTH];
      end
      OP_SUB: begin
        fast_res = dif[WIDTH-1:0];
        fast_ovf = (bus.A[MSB] != bus.B[MSB]) && (dif[MSB] != bus.A[MSB]);
        fast_cry = dif[WIDTH];
      end
      OP_SLT:  fast_res = WIDTH'($signed(bus.A) < $signed(bus.B));
      OP_NOR:  fast_res = ~(bus.A | bus.B);
      OP_XOR:  fast_res = bus.A ^ bus.B;
      OP_SLL:  fast_res = bus.B << sh;
      OP_SRL:  fast_res = bus.B >> sh;
      OP_SRA:  fast_res = WIDTH'($signed(bus.B) >>> sh);
      OP_MULU, OP_MUL: is_iter = 1'b1;
`ifdef ITER_ALU_DIV_EN
      OP_DIVU, OP_DIV: is_iter = 1'b1;
`endif
      default: ;
    endcase

`ifdef ITER_ALU_DIV_EN
    signed_op = (bus.ALUop == OP_MUL) || (bus.ALUop == OP_DIV);
`else
    signed_op = (bus.ALUop == OP_MUL);
`endif
    a_mag      = (signed_op && bus.A[MSB]) ? (WIDTH'(0) - bus.A) : bus.A;
    b_mag      = (signed_op && bus.B[MSB]) ? (WIDTH'(0) - bus.B) : bus.B;
    load_lo    = b_mag;
    load_mcand = a_mag;
`ifdef ITER_ALU_DIV_EN
    if (bus.ALUop[3:1] == 3'b110) begin
      load_lo    = a_mag;
      load_mcand = b_mag;
    end
`endif
  end

  // One shift-add (or restore-subtract) step plus the sign fix-up applied on the last step
  always_comb begin
    add     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : (WIDTH+1)'(0));
    step_hi = add[WIDTH:1];
    step_lo = {add[0], lo_q[WIDTH-1:1]};
    prod    = {step_hi, step_lo};
    if (neg_q) prod = (2*WIDTH)'(0) - prod;
    fin_hi  = prod[2*WIDTH-1:WIDTH];
    fin_lo  = prod[WIDTH-1:0];
    fin_dz  = 1'b0;
`ifdef ITER_ALU_DIV_EN
    rem_s = {hi_q, lo_q[WIDTH-1]};
    trial = rem_s - {1'b0, mcand_q};
    if (div_q) begin
      if (!trial[WIDTH]) begin
        step_hi = trial[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = rem_s[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
      fin_lo = neg_q   ? (WIDTH'(0) - step_lo) : step_lo;
      fin_hi = neg_r_q ? (WIDTH'(0) - step_hi) : step_hi;
      if (divz_q) begin
        fin_lo = '1;
        fin_hi = a_q;
        fin_dz = 1'b1;
      end
    end
`endif
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      resh_q      <= '0;
      ovf_q       <= 1'b0;
      cry_q       <= 1'b0;
      zero_q      <= 1'b0;
      dz_q        <= 1'b0;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      mcand_q     <= '0;
      neg_q       <= 1'b0;
`ifdef ITER_ALU_DIV_EN
      div_q       <= 1'b0;
      neg_r_q     <= 1'b0;
      divz_q      <= 1'b0;
      a_q         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            if (is_iter) begin
              state   <= BUSY;
              cnt_q   <= CW'(WIDTH - 1);
              hi_q    <= '0;
              lo_q    <= load_lo;
              mcand_q <= load_mcand;
              neg_q   <= signed_op && (bus.A[MSB] ^ bus.B[MSB]);
`ifdef ITER_ALU_DIV_EN
              div_q   <= (bus.ALUop[3:1] == 3'b110);
              neg_r_q <= signed_op && bus.A[MSB];
              divz_q  <= (bus.B == '0);
              a_q     <= bus.A;
`endif
            end else begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              res_q       <= fast_res;
              resh_q      <= '0;
              ovf_q       <= fast_ovf;
              cry_q       <= fast_cry;
              zero_q      <= (fast_res == '0);
              dz_q        <= 1'b0;
            end
          end
        end
        BUSY: begin
          hi_q  <= step_hi;
          lo_q  <= step_lo;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            res_q       <= fin_lo;
            resh_q      <= fin_hi;
            ovf_q       <= 1'b0;
            cry_q       <= 1'b0;
            zero_q      <= (fin_lo == '0);
            dz_q        <= fin_dz;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
